// File: rtl/softmax_exp_sequencer.sv
// softmax_exp_sequencer: loads a score vector, sends (score - max) to one exp unit, then sums and streams the results
module softmax_exp_sequencer #(
   parameter int VEC_LEN      = 8,
   parameter int IN_WIDTH     = 33,
   parameter int IN_FRAC_BITS = 16,
   parameter int Y_WIDTH      = 16,
   parameter int SUM_WIDTH    = Y_WIDTH + $clog2(VEC_LEN),
   parameter int TIMEOUT      = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic                        busy,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic signed [IN_WIDTH-1:0]  s_data,
   output logic                        exp_start,
   output logic signed [IN_WIDTH-1:0]  exp_x,
   input  logic                        exp_done,
   input  logic        [Y_WIDTH-1:0]   exp_y,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic        [Y_WIDTH-1:0]   m_data,
   output logic                        m_last,
   output logic        [SUM_WIDTH-1:0] sum_out,
   output logic                        done,
   output logic                        err_timeout
);
   localparam int IW = $clog2(VEC_LEN);
   localparam int TW = $clog2(TIMEOUT + 1);
   if (IN_FRAC_BITS >= IN_WIDTH || VEC_LEN < 2) begin : g_bad_param
      $error("softmax_exp_sequencer: invalid parameters");
   end
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, STREAM, DONE} state_t;
   state_t state, state_nx;
   logic        [IW-1:0]        idx;
   logic signed [IN_WIDTH-1:0]  sbuf [VEC_LEN];
   logic        [Y_WIDTH-1:0]   ybuf [VEC_LEN];
   logic signed [IN_WIDTH-1:0]  max_r;
   logic        [SUM_WIDTH-1:0] sum;
   logic        [TW-1:0]        timer;
   logic signed [IN_WIDTH:0]    diff;
   logic signed [IN_WIDTH-1:0]  x_sat;
   logic        [Y_WIDTH-1:0]   y_in;
   logic last, tmo, res_fire;
   // score <= max always, so the only possible overflow is below the most negative value
   assign diff     = {sbuf[idx][IN_WIDTH-1], sbuf[idx]} - {max_r[IN_WIDTH-1], max_r};
   assign x_sat    = (diff[IN_WIDTH] != diff[IN_WIDTH-1]) ? {1'b1, {(IN_WIDTH-1){1'b0}}} : diff[IN_WIDTH-1:0];
   assign last     = idx == IW'(VEC_LEN - 1);
   assign tmo      = !exp_done && timer == TW'(TIMEOUT - 1);
   assign res_fire = state == WAIT && (exp_done || tmo);
   assign y_in     = exp_done ? exp_y : Y_WIDTH'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx  = state;
      busy      = state != IDLE;
      s_ready   = state == LOAD;
      exp_start = state == ISSUE;
      exp_x     = (state == ISSUE || state == WAIT) ? x_sat : '0;
      m_valid   = state == STREAM;
      m_data    = m_valid ? ybuf[idx] : '0;
      m_last    = m_valid && last;
      done      = state == DONE;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (s_valid && last) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (res_fire) state_nx = last ? STREAM : ISSUE;
         STREAM:  if (m_ready && last) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   // idx wraps to 0 after the last element because VEC_LEN is a power of two
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx         <= '0;
         max_r       <= '0;
         sum         <= '0;
         timer       <= '0;
         sum_out     <= '0;
         err_timeout <= 1'b0;
         for (int i = 0; i < VEC_LEN; i++) begin
            sbuf[i] <= '0;
            ybuf[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: if (start) begin
               sum         <= '0;
               idx         <= '0;
               err_timeout <= 1'b0;
            end
            LOAD: if (s_valid) begin
               sbuf[idx] <= s_data;
               if (idx == '0 || s_data > max_r) max_r <= s_data;
               idx <= idx + 1'b1;
            end
            ISSUE: timer <= '0;
            WAIT: begin
               timer <= timer + 1'b1;
               if (res_fire) begin
                  ybuf[idx] <= y_in;
                  sum       <= sum + SUM_WIDTH'(y_in);
                  idx       <= idx + 1'b1;
                  if (tmo) err_timeout <= 1'b1;
               end
            end
            STREAM: if (m_ready) begin
               idx <= idx + 1'b1;
               if (last) sum_out <= sum;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_softmax_exp_sequencer.sv
// tb_softmax_exp_sequencer: randomized bench with a latency-5 exp-unit stub and a behavioural softmax front-end model
module tb_softmax_exp_sequencer;
   localparam int VL = 8, IW = 33, YW = 16, SW = YW + $clog2(VL), TO = 64, LAT = 5;
   typedef longint vec_t [VL];
   typedef int ivec_t [VL];
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b0, exp_done = 1'b0;
   logic signed [IW-1:0] s_data = '0;
   logic signed [IW-1:0] exp_x;
   logic [YW-1:0] exp_y = '0, m_data;
   logic [SW-1:0] sum_out;
   logic busy, s_ready, exp_start, m_valid, m_last, done, err_timeout;
   int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, stall_bad = 0, hang_elem = -1, stub_cnt = 0;
   longint obs_x[$];
   int obs_t[$], obs_y[$];
   bit obs_l[$];
   longint obs_sum = 0;
   bit stub_hang = 1'b0, prev_stall = 1'b0;
   logic [YW-1:0] prev_d = '0;
   logic prev_l = 1'b0;

   softmax_exp_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .exp_start(exp_start), .exp_x(exp_x), .exp_done(exp_done), .exp_y(exp_y),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .sum_out(sum_out), .done(done), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // exp unit stub: clears exp_done on the request edge, raises it LAT edges later unless told to hang
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         exp_done <= 1'b0;
         stub_cnt <= 0;
      end else if (exp_start) begin
         exp_done  <= 1'b0;
         stub_cnt  <= LAT;
         exp_y     <= (exp_x == 0) ? 16'd32768 : 16'd16384;
         stub_hang <= (obs_x.size() - 1 == hang_elem);
      end else if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1 && !stub_hang) exp_done <= 1'b1;
      end

   always @(negedge clk) begin
      if (exp_start) begin
         obs_x.push_back(longint'(exp_x));
         obs_t.push_back(cyc);
      end
      if (m_valid && m_ready) begin
         obs_y.push_back(int'(m_data));
         obs_l.push_back(m_last);
      end
      if (done) begin
         done_cnt++;
         obs_sum = longint'(sum_out);
      end
      if (prev_stall && m_valid && (m_data !== prev_d || m_last !== prev_l)) stall_bad++;
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
   end

   function automatic void model(input vec_t sc, input int hang, output vec_t ex, output ivec_t ey, output longint es);
      longint mx, lim;
      mx  = sc[0];
      lim = -(longint'(1) << (IW - 1));
      for (int i = 1; i < VL; i++) if (sc[i] > mx) mx = sc[i];
      es = 0;
      for (int i = 0; i < VL; i++) begin
         ex[i] = (sc[i] - mx < lim) ? lim : sc[i] - mx;
         ey[i] = (i == hang) ? 1 : (ex[i] == 0 ? 32768 : 16384);
         es += ey[i];
      end
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < VL; i++) v[i] = (longint'($urandom_range(0, 40)) - 20) * 'h4000;
      return v;
   endfunction

   task automatic begin_vector(input vec_t sc, input bit gaps);
      obs_x.delete(); obs_t.delete(); obs_y.delete(); obs_l.delete();
      done_cnt = 0;
      stall_bad = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < VL; i++) begin
         if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
            end
         end
         s_valid = 1'b1;
         s_data  = sc[i][IW-1:0];
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic finish_vector(input bit bp, input bit poke);
      m_ready = 1'b1;
      for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
         @(posedge clk); #1;
         if (bp) m_ready = ~m_ready;
         start = poke && c < 40 && c % 2 == 0;
      end
      start = 1'b0;
      m_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({busy, s_ready, exp_start, m_valid, m_last, done, err_timeout} !== 7'b0 || exp_x !== '0 || m_data !== '0 || sum_out !== '0) begin
         n_err++;
         $display("FAIL reset: ctl=%b exp_x=%0d m_data=%0d sum_out=%0d, want all 0",
                  {busy, s_ready, exp_start, m_valid, m_last, done, err_timeout}, exp_x, m_data, sum_out);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_patterns();
      vec_t sc, ex;
      ivec_t ey;
      longint es;
      int gap;
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < VL; i++)
            sc[i] = p == 0 ? 0 : p == 1 ? (i == VL - 1 ? 'h30000 : 'h10000)
                  : $urandom_range(0, 1) ? (longint'(1) << 32) - 1 : -(longint'(1) << 32);
         if (p == 2) begin
            sc[1] = -(longint'(1) << 32);
            sc[6] = (longint'(1) << 32) - 1;
         end
         if (p > 2) sc = rand_vec();
         model(sc, -1, ex, ey, es);
         begin_vector(sc, p > 2);
         finish_vector(1'b0, 1'b0);
         for (int i = 0; i < VL; i++) begin
            gap = i > 0 ? obs_t[i] - obs_t[i-1] : LAT + 2;
            n_vec++;
            if (obs_x[i] !== ex[i] || obs_y[i] !== ey[i] || obs_l[i] !== (i == VL - 1) || gap != LAT + 2) begin
               n_err++;
               $display("FAIL pattern %0d elem %0d: exp_x %0d want %0d, m_data %0d want %0d, m_last %0b want %0b, gap %0d want %0d",
                        p, i, obs_x[i], ex[i], obs_y[i], ey[i], obs_l[i], i == VL - 1, gap, LAT + 2);
            end
         end
         n_vec++;
         if (obs_x.size() != VL || obs_y.size() != VL || done_cnt != 1) begin
            n_err++;
            $display("FAIL pattern %0d counts: requests %0d beats %0d dones %0d, want %0d %0d 1", p, obs_x.size(), obs_y.size(), done_cnt, VL, VL);
         end
         n_vec++;
         if (obs_sum !== es || longint'(sum_out) !== es) begin
            n_err++;
            $display("FAIL pattern %0d sum: at done %0d, held %0d, want %0d", p, obs_sum, sum_out, es);
         end
      end
   endtask

   task automatic test_backpressure();
      vec_t sc, ex;
      ivec_t ey;
      longint es;
      sc = rand_vec();
      model(sc, -1, ex, ey, es);
      begin_vector(sc, 1'b1);
      finish_vector(1'b1, 1'b0);
      for (int i = 0; i < VL; i++) begin
         n_vec++;
         if (obs_y[i] !== ey[i] || obs_l[i] !== (i == VL - 1)) begin
            n_err++;
            $display("FAIL backpressure elem %0d: m_data %0d want %0d, m_last %0b want %0b", i, obs_y[i], ey[i], obs_l[i], i == VL - 1);
         end
      end
      n_vec++;
      if (stall_bad != 0 || obs_y.size() != VL || obs_sum !== es) begin
         n_err++;
         $display("FAIL backpressure: stall changes %0d want 0, beats %0d want %0d, sum %0d want %0d", stall_bad, obs_y.size(), VL, obs_sum, es);
      end
   endtask

   task automatic test_start_while_busy();
      vec_t sc, ex;
      ivec_t ey;
      longint es;
      sc = rand_vec();
      model(sc, -1, ex, ey, es);
      begin_vector(sc, 1'b0);
      finish_vector(1'b0, 1'b1);
      n_vec++;
      if (obs_x.size() != VL || done_cnt != 1 || busy !== 1'b0 || obs_sum !== es) begin
         n_err++;
         $display("FAIL start_while_busy: requests %0d want %0d, dones %0d want 1, busy %b want 0, sum %0d want %0d",
                  obs_x.size(), VL, done_cnt, busy, obs_sum, es);
      end
   endtask

   task automatic test_timeout();
      vec_t sc, ex;
      ivec_t ey;
      longint es;
      sc = rand_vec();
      model(sc, 3, ex, ey, es);
      hang_elem = 3;
      begin_vector(sc, 1'b0);
      finish_vector(1'b0, 1'b0);
      hang_elem = -1;
      n_vec++;
      if (obs_y[3] !== 1 || err_timeout !== 1'b1) begin
         n_err++;
         $display("FAIL timeout flag: ybuf[3] %0d want 1, err_timeout %b want 1", obs_y[3], err_timeout);
      end
      n_vec++;
      if (obs_t[4] - obs_t[3] != TO + 1) begin
         n_err++;
         $display("FAIL timeout gap: %0d cycles want %0d", obs_t[4] - obs_t[3], TO + 1);
      end
      n_vec++;
      if (done_cnt != 1 || obs_sum !== es || obs_y.size() != VL) begin
         n_err++;
         $display("FAIL timeout completion: dones %0d want 1, sum %0d want %0d, beats %0d want %0d", done_cnt, obs_sum, es, obs_y.size(), VL);
      end
      sc = rand_vec();
      model(sc, -1, ex, ey, es);
      begin_vector(sc, 1'b0);
      finish_vector(1'b0, 1'b0);
      n_vec++;
      if (err_timeout !== 1'b0 || obs_sum !== es) begin
         n_err++;
         $display("FAIL timeout clear on start: err_timeout %b want 0, sum %0d want %0d", err_timeout, obs_sum, es);
      end
   endtask

   task automatic test_reset_mid();
      vec_t sc, ex;
      ivec_t ey;
      longint es;
      sc = rand_vec();
      hang_elem = 1;
      begin_vector(sc, 1'b0);
      m_ready = 1'b1;
      for (int c = 0; c < 400 && obs_x.size() < 3; c++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      hang_elem = -1;
      n_vec++;
      if (err_timeout !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid setup: err_timeout %b busy %b, want 1 1", err_timeout, busy);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, s_ready, exp_start, m_valid, m_last, done, err_timeout} !== 7'b0 || exp_x !== '0 || m_data !== '0 || sum_out !== '0) begin
         n_err++;
         $display("FAIL reset_mid outputs: ctl=%b exp_x=%0d m_data=%0d sum_out=%0d, want all 0",
                  {busy, s_ready, exp_start, m_valid, m_last, done, err_timeout}, exp_x, m_data, sum_out);
      end
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      n_vec++;
      if (done_cnt != 0) begin
         n_err++;
         $display("FAIL reset_mid done: %0d pulses want 0", done_cnt);
      end
      sc = rand_vec();
      model(sc, -1, ex, ey, es);
      begin_vector(sc, 1'b1);
      finish_vector(1'b0, 1'b0);
      n_vec++;
      if (err_timeout !== 1'b0 || done_cnt != 1 || obs_sum !== es || obs_x.size() != VL) begin
         n_err++;
         $display("FAIL reset_mid rerun: err_timeout %b want 0, dones %0d want 1, sum %0d want %0d, requests %0d want %0d",
                  err_timeout, done_cnt, obs_sum, es, obs_x.size(), VL);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_patterns();
      test_backpressure();
      test_start_while_busy();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
